motion_alarm_controller: RTL

MOTION_ALARM_CONTROLLER -- requirements
Module: motion_alarm_controller

---
 rtl/motion_alarm_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/motion_alarm_controller.sv
// Three-zone PIR motion alarm: 2-flop synchronizers, per-sensor debounce,
// and an OFF/ARMING/ARMED/ALARM/COOLDOWN controller with registered outputs.
module motion_alarm_controller #(
    parameter int unsigned ARM_DELAY  = 8,
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned ALARM_HOLD = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turn,
    input  logic       stop_alarm,
    input  logic       pir_sensor_1,
    input  logic       pir_sensor_2,
    input  logic       pir_sensor_3,
    output logic       alarm,
    output logic       armed,
    output logic [2:0] zone,
    output logic [7:0] alarm_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_ARMING   = 3'd1,
        S_ARMED    = 3'd2,
        S_ALARM    = 3'd3,
        S_COOLDOWN = 3'd4
    } state_e;

    localparam logic [15:0] ARM_DELAY_C  = 16'(ARM_DELAY);
    localparam logic [15:0] ALARM_HOLD_C = 16'(ALARM_HOLD);
    localparam logic [7:0]  DEBOUNCE_C   = 8'(DEBOUNCE);

    state_e          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic            alarm_q, alarm_d;
    logic            armed_q, armed_d;
    logic [2:0]      zone_q, zone_d;
    logic [7:0]      count_q, count_d;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [2:0][7:0] deb_q, deb_d;
    logic [2:0]      qual;

    always_comb begin
        sync1_d = {pir_sensor_3, pir_sensor_2, pir_sensor_1};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        qual    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            qual[i] = (deb_q[i] == DEBOUNCE_C);
            if (!sync2_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] != DEBOUNCE_C) begin
                deb_d[i] = deb_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        count_d = count_q;
        timer_d = timer_q;
        if (!turn) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_ARMING;
                    zone_d  = '0;
                end
                S_ARMING: begin
                    if (timer_q <= 16'd1) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (|qual) begin
                        state_d = S_ALARM;
                        zone_d  = qual;
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    end
                end
                S_ALARM: begin
                    zone_d = zone_q | qual;
                    if (stop_alarm || timer_q <= 16'd1) state_d = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (timer_q <= 16'd1) state_d = S_ARMED;
                end
                default: state_d = S_OFF;
            endcase
        end

        // One shared timer: reloaded on any state change, otherwise counts down to 1 and parks.
        if (state_d != state_q) begin
            case (state_d)
                S_ARMING, S_COOLDOWN: timer_d = ARM_DELAY_C;
                S_ALARM:              timer_d = ALARM_HOLD_C;
                default:              timer_d = '0;
            endcase
        end else if (timer_q > 16'd1) begin
            timer_d = timer_q - 16'd1;
        end

        alarm_d = (state_d == S_ALARM);
        armed_d = (state_d == S_ARMED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            timer_q <= '0;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
            zone_q  <= '0;
            count_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            alarm_q <= alarm_d;
            armed_q <= armed_d;
            zone_q  <= zone_d;
            count_q <= count_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
        end
    end

    assign alarm       = alarm_q;
    assign armed       = armed_q;
    assign zone        = zone_q;
    assign alarm_count = count_q;
    assign state       = state_q;

endmodule
